parsing_data_fifo: RTL and testbench

PARSING_DATA_FIFO -- requirements
Module: parsing_data_fifo

---
 rtl/parsing_data_fifo.sv | 154 +++++++++++++++
 tb/tb_parsing_data_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parsing_data_fifo.sv
// rtl/parsing_data_fifo.sv - FWFT 128-bit beat FIFO between parser and consumer, with frame-done pulse and overflow flag
// Optional occupancy output oCount is compiled in when PARSING_DATA_FIFO_COUNT_EN is defined.
module parsing_data_fifo #(
  parameter int DEPTH       = 16,
  parameter int AF_THRESH   = 12,
  parameter int FRAME_BEATS = 512
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [7:0]   iDin0,
  input  logic [7:0]   iDin1,
  input  logic [7:0]   iDin2,
  input  logic [7:0]   iDin3,
  input  logic [7:0]   iDin4,
  input  logic [7:0]   iDin5,
  input  logic [7:0]   iDin6,
  input  logic [7:0]   iDin7,
  input  logic [7:0]   iDin8,
  input  logic [7:0]   iDin9,
  input  logic [7:0]   iDin10,
  input  logic [7:0]   iDin11,
  input  logic [7:0]   iDin12,
  input  logic [7:0]   iDin13,
  input  logic [7:0]   iDin14,
  input  logic [7:0]   iDin15,
  input  logic         iValid,
  input  logic         iClear,
  output logic         oRun,
  output logic [127:0] oData,
  output logic         oValid,
  input  logic         iReady,
  output logic         oFrameDone,
  output logic         oOverflow
`ifdef PARSING_DATA_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] oCount
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  logic [127:0] mem_q [DEPTH];
  logic [127:0] din_beat;

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]  occ_d;
  logic [FW-1:0] frame_q, frame_d;
  logic         run_q, run_d;
  logic         done_q, done_d;
  logic         ovf_q, ovf_d;
  state_t       state_q, state_d;

  logic         fifo_empty;
  logic         fifo_full;
  logic         push;
  logic         pop;

  assign din_beat = {iDin15, iDin14, iDin13, iDin12, iDin11, iDin10, iDin9, iDin8,
                     iDin7,  iDin6,  iDin5,  iDin4,  iDin3,  iDin2,  iDin1, iDin0};

  assign pop  = oValid & iReady;
  assign push = iValid & (~fifo_full | pop);

  // Next-state for pointers, frame counter, run enable and overflow; clear overrides everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    frame_d  = frame_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    if (iClear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      frame_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        if (frame_q == FW'(FRAME_BEATS - 1)) begin
          frame_d = '0;
          done_d  = 1'b1;
        end else begin
          frame_d = frame_q + {{(FW-1){1'b0}}, 1'b1};
        end
      end
      if (iValid && fifo_full && !pop) ovf_d = 1'b1;
    end
    occ_d = wr_ptr_d - rd_ptr_d;
    run_d = ~iClear & (32'(occ_d) < AF_THRESH);
  end

  // Control registers; reset holds the FIFO empty and the parser stalled
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      frame_q  <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      frame_q  <= frame_d;
      run_q    <= run_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Beat storage is not reset; it is only read while the FIFO holds data
  always_ff @(posedge clk) begin
    if (push && !iClear) mem_q[wr_ptr_q[AW-1:0]] <= din_beat;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state follows the occupancy that will hold after this edge
  always_comb begin
    state_d = S_ACTIVE;
    if (occ_d == '0)                      state_d = S_IDLE;
    else if (occ_d == (AW+1)'(DEPTH))     state_d = S_FULL;
  end

  // FSM outputs: empty/full flags and the fall-through head beat
  always_comb begin
    fifo_empty = (state_q == S_IDLE);
    fifo_full  = (state_q == S_FULL);
    oValid     = ~fifo_empty;
    oData      = fifo_empty ? 128'd0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  assign oRun       = run_q;
  assign oFrameDone = done_q;
  assign oOverflow  = ovf_q;

`ifdef PARSING_DATA_FIFO_COUNT_EN
  assign oCount = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_parsing_data_fifo.sv
// tb/tb_parsing_data_fifo.sv - directed self-checking bench for parsing_data_fifo
module tb_parsing_data_fifo;

  logic         clk;
  logic         rstn;
  logic [7:0]   din [16];
  logic         iValid;
  logic         iClear;
  logic         iReady;
  logic         oRun;
  logic [127:0] oData;
  logic         oValid;
  logic         oFrameDone;
  logic         oOverflow;
`ifdef PARSING_DATA_FIFO_COUNT_EN
  logic [4:0]   oCount;
`endif

  int n_vec;
  int n_err;

  parsing_data_fifo dut (
    .clk        (clk),
    .rstn       (rstn),
    .iDin0      (din[0]),
    .iDin1      (din[1]),
    .iDin2      (din[2]),
    .iDin3      (din[3]),
    .iDin4      (din[4]),
    .iDin5      (din[5]),
    .iDin6      (din[6]),
    .iDin7      (din[7]),
    .iDin8      (din[8]),
    .iDin9      (din[9]),
    .iDin10     (din[10]),
    .iDin11     (din[11]),
    .iDin12     (din[12]),
    .iDin13     (din[13]),
    .iDin14     (din[14]),
    .iDin15     (din[15]),
    .iValid     (iValid),
    .iClear     (iClear),
    .oRun       (oRun),
    .oData      (oData),
    .oValid     (oValid),
    .iReady     (iReady),
    .oFrameDone (oFrameDone),
    .oOverflow  (oOverflow)
`ifdef PARSING_DATA_FIFO_COUNT_EN
    ,
    .oCount     (oCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int k = 0; k < 16; k++) din[k] = v;
  endtask

  function automatic logic [127:0] rep(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {16{b}};
  endfunction

  task automatic do_clear();
    iValid = 1'b0;
    iReady = 1'b0;
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    tick();
  endtask

  initial begin
    int pops;
    int pulses;
    int first_at;
    int second_at;
    logic pop_now;

    n_vec  = 0;
    n_err  = 0;
    rstn   = 1'b1;
    iValid = 1'b0;
    iClear = 1'b0;
    iReady = 1'b0;
    set_all(8'h00);

    // reset state
    tick();
    iValid = 1'b1;
    tick();
    chk("rst_valid", oValid, 1'b0);
    chk("rst_data", oData, 128'd0);
    chk("rst_run", oRun, 1'b0);
    chk("rst_fdone", oFrameDone, 1'b0);
    chk("rst_ovf", oOverflow, 1'b0);
    iValid = 1'b0;
    rstn = 1'b0;
    tick();
    chk("run_after_rst", oRun, 1'b1);
    chk("empty_after_rst", oValid, 1'b0);

    // single beat, lanes k
    for (int k = 0; k < 16; k++) din[k] = 8'(k);
    iValid = 1'b1;
    iReady = 1'b1;
    tick();
    iValid = 1'b0;
    chk("single_valid", oValid, 1'b1);
    chk("single_data", oData, 128'h0F0E0D0C0B0A09080706050403020100);
    tick();
    chk("single_drained", oValid, 1'b0);
    chk("single_zero", oData, 128'd0);

    // almost-full run throttle
    iReady = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      set_all(8'(i));
      iValid = 1'b1;
      tick();
      if (i == 11) chk("run_at_11", oRun, 1'b1);
    end
    iValid = 1'b0;
    chk("run_at_12", oRun, 1'b0);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    chk("run_after_pop", oRun, 1'b1);
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    chk("run_in_clear", oRun, 1'b0);
    chk("clear_empty", oValid, 1'b0);
    tick();
    chk("run_after_clear", oRun, 1'b1);

    // overflow: 17 pushes into 16 entries
    for (int i = 1; i <= 17; i++) begin
      set_all(8'(i));
      iValid = 1'b1;
      tick();
      if (i == 16) chk("ovf_at_16", oOverflow, 1'b0);
    end
    iValid = 1'b0;
    chk("ovf_at_17", oOverflow, 1'b1);
    chk("ovf_run", oRun, 1'b0);
    iReady = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("ovf_drain_%0d", i), oData, rep(i));
      tick();
    end
    iReady = 1'b0;
    chk("ovf_17_absent", oValid, 1'b0);
    chk("ovf_sticky", oOverflow, 1'b1);
    do_clear();
    chk("ovf_cleared", oOverflow, 1'b0);

    // full with simultaneous push/pop across pointer wrap
    for (int i = 1; i <= 16; i++) begin
      set_all(8'(i));
      iValid = 1'b1;
      tick();
    end
    iReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      set_all(8'(17 + c));
      chk($sformatf("wrap_head_%0d", c), oData, rep(1 + c));
      tick();
    end
    iValid = 1'b0;
    iReady = 1'b0;
    chk("wrap_no_ovf", oOverflow, 1'b0);
    chk("wrap_run", oRun, 1'b0);
`ifdef PARSING_DATA_FIFO_COUNT_EN
    chk("wrap_count", oCount, 5'd16);
`endif
    iReady = 1'b1;
    for (int i = 21; i <= 36; i++) begin
      chk($sformatf("wrap_drain_%0d", i), oData, rep(i));
      tick();
    end
    iReady = 1'b0;
    chk("wrap_exact_16", oValid, 1'b0);

    // clear with 5 entries, pending push, overflow set and frame counter advanced
    for (int i = 1; i <= 17; i++) begin
      set_all(8'(i));
      iValid = 1'b1;
      tick();
    end
    iValid = 1'b0;
    iReady = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    iReady = 1'b0;
    chk("pre_clear_head", oData, rep(12));
    iValid = 1'b1;
    iReady = 1'b1;
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    chk("clr_valid", oValid, 1'b0);
    chk("clr_ovf", oOverflow, 1'b0);
    chk("clr_data", oData, 128'd0);
`ifdef PARSING_DATA_FIFO_COUNT_EN
    chk("clr_count", oCount, 5'd0);
`endif

    // 1024 continuous beats: frame done at pops 512 and 1024
    pops = 0;
    pulses = 0;
    first_at = -1;
    second_at = -1;
    iValid = 1'b1;
    iReady = 1'b1;
    for (int c = 0; c < 1100 && pops < 1024; c++) begin
      set_all(8'(c));
      pop_now = oValid & iReady;
      tick();
      if (pop_now) pops++;
      if (oFrameDone) begin
        pulses++;
        if (pulses == 1) first_at = pops;
        if (pulses == 2) second_at = pops;
      end
    end
    iValid = 1'b0;
    iReady = 1'b0;
    chk("frame_pops", 32'(pops), 32'd1024);
    chk("frame_pulses", 32'(pulses), 32'd2);
    chk("frame_first", 32'(first_at), 32'd512);
    chk("frame_second", 32'(second_at), 32'd1024);
    tick();
    chk("frame_one_cycle", oFrameDone, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
